uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the single UART transmit FIFO write port (twr_en/twr_data/tx_full)
//   between NREQ byte-stream requesters. Grants one requester per packet using
//   round-robin order, and forwards its bytes into the TX FIFO under tx_full
//   backpressure. A byte cap per grant stops any single requester hogging the
//   UART. Sits between on-chip message sources and the uart top-level.
// PARAMETERS
//   NREQ    4   number of requesters (>=2)
//   NBITS   8   data width; must match the uart nbits
//   MAX_PKT 16  max bytes accepted per grant before forced release (>=1)
// PORTS
//   clk       in   1           system clock, rising edge
//   reset     in   1           asynchronous, active-low reset
//   req_valid in   NREQ        requester i has a byte on req_data slice i
//   req_data  in   NREQ*NBITS  byte of requester i at [i*NBITS +: NBITS]
//   req_last  in   NREQ        byte of requester i is last of its packet
//   req_ready out  NREQ        byte of requester i accepted this cycle if valid
//   twr_en    out  1           TX FIFO write enable (to uart twr_en)
//   twr_data  out  NBITS       TX FIFO write data (to uart twr_data)
//   tx_full   in   1           TX FIFO full (from uart)
//   grant     out  NREQ        one-hot current owner, registered; 0 when idle
//   busy      out  1           1 while a grant is held (state LOCK)
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, grant=0, rr_ptr=0, byte_cnt=0.
//     This gives twr_en=0, req_ready=0, busy=0 while reset is held and after.
//   FSM states are IDLE and LOCK.
//   IDLE
//     Search req_valid starting at rr_ptr, wrapping NREQ-1 -> 0, and take the
//     first set bit g. On the next edge: grant=onehot(g), state=LOCK,
//     byte_cnt=0.
//     Arbitration latency is 1 cycle. No data moves in IDLE.
//   LOCK (owner g)
//     req_ready[g] = ~tx_full; all other req_ready bits = 0 (combinational).
//     twr_en   = req_valid[g] & ~tx_full.
//     twr_data = req_data slice g. twr_data is 0 whenever grant=0.
//     A transfer occurs when twr_en=1. A transfer increments byte_cnt.
//     Release happens on a transfer that has req_last[g]=1, or on the transfer
//       that makes byte_cnt==MAX_PKT. On the next edge: state=IDLE, grant=0,
//       byte_cnt=0, rr_ptr=(g+1) mod NREQ.
//     If req_valid[g] drops mid-packet, the grant is held. Bytes resume when
//       valid returns. There is no timeout.
//     tx_full=1 stalls: no write, no count, state held. A requester must keep
//       req_data and req_last stable while req_valid=1 and req_ready=0.
//   Back-to-back packets have a 1-cycle bubble (the IDLE cycle) between grants.
//     Sustained peak is MAX_PKT bytes per MAX_PKT+1 cycles.
//   Simultaneous events
//     last and cap on the same transfer cause a single release.
//     A release cycle with another requester valid: that requester is chosen
//       in the following IDLE cycle, starting the search from g+1.
//   A forced release at MAX_PKT does not signal the requester. Its remaining
//     bytes continue as a new packet on a later grant.
//   byte_cnt width is $clog2(MAX_PKT+1). It never exceeds MAX_PKT.
//   Reset asserted mid-packet aborts immediately. Bytes already written stay
//     in the FIFO, and the partial packet is not resumed.
// TESTING
//   1. Reset 0->1, all req_valid=0. Required: twr_en=0, grant=0, busy=0 for
//      20 cycles.
//   2. Req1 alone sends 3 bytes 8'hA1,8'hA2,8'hA3 (last on the third), tx_full=0.
//      Required: grant=4'b0010 one cycle after valid. twr_data A1,A2,A3 on 3
//      consecutive twr_en cycles. Then grant=0.
//   3. All 4 requesters each send a 1-byte packet with req_valid held.
//      Required: grant order 0,1,2,3 then 0. Exactly one idle cycle between grants.
//   4. Req2 sends a 20-byte packet with MAX_PKT=16 and req3 valid.
//      Required: 16 bytes written, then release. Next grant is req3 (rr_ptr=3).
//      Req2 resumes with byte 17 afterwards.
//   5. tx_full=1 for 5 cycles mid-packet. Required: twr_en=0 and req_ready=0
//      during the stall. No byte is lost or duplicated, and byte_cnt is unchanged.
//   6. reset=0 asynchronously mid-packet. Required: grant, twr_en and req_ready
//      are 0 before the next clk edge. After reset the first grant follows from
//      rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares the single UART TX FIFO write port among NREQ byte-stream
//   requesters. One requester is granted per packet in round-robin order. Its
//   bytes are forwarded to the FIFO, and tx_full applies backpressure. A grant
//   is released on the byte flagged last, or after MAX_PKT bytes, whichever
//   comes first.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   req_valid  in   [NREQ]        requester i presents a byte
//   req_data   in   [NREQ*NBITS]  byte of requester i at [i*NBITS +: NBITS]
//   req_last   in   [NREQ]        byte of requester i ends its packet
//   req_ready  out  [NREQ]        byte of requester i accepted this cycle if valid
//   twr_en     out                TX FIFO write enable
//   twr_data   out  [NBITS]       TX FIFO write data (0 while no grant)
//   tx_full    in                 TX FIFO full
//   grant      out  [NREQ]        one-hot registered owner, 0 when idle
//   busy       out                a grant is held
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int NBITS   = 8,
    parameter int MAX_PKT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*NBITS-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic                  twr_en,
    output logic [NBITS-1:0]      twr_data,
    input  logic                  tx_full,
    output logic [NREQ-1:0]       grant,
    output logic                  busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_PKT + 1);
    localparam logic [CW-1:0] CNT_CAP_M1 = CW'(MAX_PKT - 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(NREQ - 1);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   byte_cnt_q, byte_cnt_d;

    logic [NBITS-1:0] data_gated [NREQ];
    logic [NBITS-1:0] sel_data;
    logic             sel_valid;
    logic             sel_last;
    logic             release_now;
    logic             found;
    logic [PW-1:0]    pick;

    // Because grant_q is zero outside LOCK, gating each slice with its grant
    // bit gives both the owner mux and the zero-when-idle output.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign data_gated[gi] = grant_q[gi] ? req_data[gi*NBITS +: NBITS] : '0;
            assign req_ready[gi]  = grant_q[gi] & ~tx_full;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_data = sel_data | data_gated[i];
        end
    end

    assign sel_valid   = |(req_valid & grant_q);
    assign sel_last    = |(req_last & grant_q);
    assign twr_en      = sel_valid & ~tx_full;
    assign twr_data    = sel_data;
    assign grant       = grant_q;
    assign busy        = (state_q == LOCK);
    // The transfer that brings the count to MAX_PKT is the one seen while
    // the count still reads MAX_PKT-1.
    assign release_now = twr_en & (sel_last | (byte_cnt_q == CNT_CAP_M1));

    // Round-robin search: the first valid requester at or after rr_ptr,
    // wrapping from NREQ-1 back to 0.
    always_comb begin : p_search
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        byte_cnt_d = byte_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = LOCK;
                    grant_d    = {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    owner_d    = pick;
                    byte_cnt_d = '0;
                end
            end
            LOCK: begin
                if (release_now) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    byte_cnt_d = '0;
                    rr_ptr_d   = (owner_q == PTR_LAST) ? '0 : owner_q + PW'(1);
                end else if (twr_en) begin
                    byte_cnt_d = byte_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

endmodule
